// File: rtl/vectored_interrupt_controller_pkg.sv
// Shared types for the vectored interrupt controller and the CSR unit.
package CSR_UnitTypes;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    FIRE   = 2'd2,
    SETTLE = 2'd3
  } IntCtrlState;

  localparam logic MTVEC_VECTORED = 1'b1;

endpackage

// File: rtl/interrupt_priority_encoder.sv
// Fixed-priority encoder: the lowest set bit of reqVec wins.
module interrupt_priority_encoder #(
  parameter int NUM_SOURCES = 8,
  localparam int IW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic [NUM_SOURCES-1:0] reqVec,
  output logic                   found,
  output logic [IW-1:0]          index
);

  // Scan high to low so the last hit (lowest index) overrides.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (reqVec[i]) begin
        found = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/vectored_interrupt_controller.sv
// Multi-source interrupt arbiter with a drain/fire sequence toward NextPC and the CSR unit.
// state  | meaning
// IDLE   | no enabled request; fetch runs
// DRAIN  | fetch stalled, waiting for empty pipeline and idle recovery manager
// FIRE   | one-cycle trigger with latched code, mepc and target
// SETTLE | one cycle for the CSR unit to drop MIE
module vectored_interrupt_controller
  import CSR_UnitTypes::*;
#(
  parameter int                     NUM_SOURCES   = 8,
  parameter int                     CODE_WIDTH    = 5,
  parameter int                     PC_WIDTH      = 32,
  parameter logic [NUM_SOURCES-1:0] EDGE_MASK     = '0,
  parameter int                     DRAIN_TIMEOUT = 1023
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              globalEnable,
  input  logic [NUM_SOURCES-1:0]            srcIn,
  input  logic [NUM_SOURCES-1:0]            srcEnable,
  input  logic [NUM_SOURCES*CODE_WIDTH-1:0] srcCode,
  input  logic [NUM_SOURCES-1:0]            srcClear,
  input  logic [PC_WIDTH-1:0]               mtvecBase,
  input  logic                              mtvecVectored,
  input  logic                              pipelineEmpty,
  input  logic                              recoveryBusy,
  input  logic [PC_WIDTH-1:0]               currentPC,
  output logic                              fetchStall,
  output logic                              triggerInterrupt,
  output logic [CODE_WIDTH-1:0]             interruptCode,
  output logic [PC_WIDTH-1:0]               interruptRetAddr,
  output logic [PC_WIDTH-1:0]               interruptTargetAddr,
  output logic [NUM_SOURCES-1:0]            pendingOut,
  output logic                              drainTimeout
);

  localparam int IW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] COUNT_MAX  = CW'(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] COUNT_LAST = CW'(DRAIN_TIMEOUT - 1);

  IntCtrlState state, stateNext;

  logic [NUM_SOURCES-1:0] srcPrev, pendingEdge, pending, enPending, risen, clearMask;
  logic                   found, req, drainReady;
  logic [IW-1:0]          winIdx, firedIdx;
  logic [CODE_WIDTH-1:0]  winCode;
  logic [PC_WIDTH-1:0]    trapBase, vecOffset, targetAddr;
  logic [CW-1:0]          counter;

  assign pending    = (pendingEdge & EDGE_MASK) | (srcIn & ~EDGE_MASK);
  assign enPending  = pending & srcEnable;
  assign risen      = srcIn & ~srcPrev & EDGE_MASK;
  assign req        = globalEnable & found;
  assign drainReady = pipelineEmpty & ~recoveryBusy;
  assign pendingOut = pending;

  interrupt_priority_encoder #(.NUM_SOURCES(NUM_SOURCES)) uEncoder (
    .reqVec (enPending),
    .found  (found),
    .index  (winIdx)
  );

  always_comb begin
    winCode = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (winIdx == IW'(i)) winCode = srcCode[i*CODE_WIDTH +: CODE_WIDTH];
    end
  end

  assign trapBase   = {mtvecBase[PC_WIDTH-1:2], 2'b00};
  assign vecOffset  = PC_WIDTH'({winCode, 2'b00});
  assign targetAddr = (mtvecVectored == MTVEC_VECTORED) ? trapBase + vecOffset : trapBase;

  // A new rising edge in the same cycle as a clear keeps the bit set.
  always_comb begin
    clearMask = srcClear;
    if (state == FIRE) clearMask[firedIdx] = 1'b1;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:   if (req) stateNext = DRAIN;
      DRAIN: begin
        if (!req)            stateNext = IDLE;
        else if (drainReady) stateNext = FIRE;
      end
      FIRE:   stateNext = SETTLE;
      SETTLE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign fetchStall       = (state != IDLE);
  assign triggerInterrupt = (state == FIRE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      srcPrev             <= '0;
      pendingEdge         <= '0;
      counter             <= '0;
      drainTimeout        <= 1'b0;
      firedIdx            <= '0;
      interruptCode       <= '0;
      interruptRetAddr    <= '0;
      interruptTargetAddr <= '0;
    end else begin
      state        <= stateNext;
      srcPrev      <= srcIn;
      pendingEdge  <= ((pendingEdge & ~clearMask) | risen) & EDGE_MASK;
      drainTimeout <= 1'b0;
      if (state == IDLE && req) counter <= '0;
      if (state == DRAIN && req) begin
        if (drainReady) begin
          firedIdx            <= winIdx;
          interruptCode       <= winCode;
          interruptRetAddr    <= currentPC;
          interruptTargetAddr <= targetAddr;
        end else begin
          if (counter != COUNT_MAX) counter <= counter + 1'b1;
          drainTimeout <= (counter == COUNT_LAST);
        end
      end
    end
  end

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Self-checking bench: directed sequences, a target-address table and a random run against a reference model.
module tb_vectored_interrupt_controller;

  localparam int NS = 8;
  localparam int CWD = 5;
  localparam int PW = 32;
  localparam int T = 12;
  localparam logic [NS-1:0] EM = 8'b1010_0010;

  logic clk = 1'b0;
  logic rst;
  logic globalEnable, mtvecVectored, pipelineEmpty, recoveryBusy;
  logic [NS-1:0] srcIn, srcEnable, srcClear;
  logic [NS*CWD-1:0] srcCode;
  logic [PW-1:0] mtvecBase, currentPC;
  logic fetchStall, triggerInterrupt, drainTimeout;
  logic [CWD-1:0] interruptCode;
  logic [PW-1:0] interruptRetAddr, interruptTargetAddr;
  logic [NS-1:0] pendingOut;

  always #5 clk = ~clk;

  vectored_interrupt_controller #(
    .NUM_SOURCES(NS), .CODE_WIDTH(CWD), .PC_WIDTH(PW), .EDGE_MASK(EM), .DRAIN_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst), .globalEnable(globalEnable), .srcIn(srcIn), .srcEnable(srcEnable),
    .srcCode(srcCode), .srcClear(srcClear), .mtvecBase(mtvecBase), .mtvecVectored(mtvecVectored),
    .pipelineEmpty(pipelineEmpty), .recoveryBusy(recoveryBusy), .currentPC(currentPC),
    .fetchStall(fetchStall), .triggerInterrupt(triggerInterrupt), .interruptCode(interruptCode),
    .interruptRetAddr(interruptRetAddr), .interruptTargetAddr(interruptTargetAddr),
    .pendingOut(pendingOut), .drainTimeout(drainTimeout)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 waiting for drain, 2 firing, 3 settling.
  int          mPhase, mWaited, mIdx;
  bit [NS-1:0] mEdge, mPrev;
  bit          mTo;
  bit [CWD-1:0] mCode;
  bit [PW-1:0] mRet, mTgt;

  task automatic modelReset();
    mPhase = 0; mWaited = 0; mIdx = 0; mEdge = '0; mPrev = '0; mTo = 0;
    mCode = '0; mRet = '0; mTgt = '0;
  endtask

  function automatic bit [NS-1:0] modelPending();
    bit [NS-1:0] p;
    for (int i = 0; i < NS; i++) p[i] = EM[i] ? mEdge[i] : srcIn[i];
    return p;
  endfunction

  task automatic modelAdvance();
    bit [NS-1:0] p, nEdge;
    int win;
    bit want;
    longint b, t;
    p = modelPending();
    win = -1;
    for (int i = 0; i < NS; i++) if (p[i] && srcEnable[i] && win < 0) win = i;
    want = globalEnable && (win >= 0);
    for (int i = 0; i < NS; i++) begin
      if (!EM[i]) nEdge[i] = 1'b0;
      else if (srcIn[i] && !mPrev[i]) nEdge[i] = 1'b1;
      else if (srcClear[i] || (mPhase == 2 && mIdx == i)) nEdge[i] = 1'b0;
      else nEdge[i] = mEdge[i];
    end
    mTo = 0;
    case (mPhase)
      0: if (want) begin mPhase = 1; mWaited = 0; end
      1: begin
        if (!want) mPhase = 0;
        else if (pipelineEmpty && !recoveryBusy) begin
          mIdx = win;
          mCode = srcCode[win*CWD +: CWD];
          mRet = currentPC;
          b = longint'(mtvecBase);
          b = b - (b % 4);
          t = mtvecVectored ? b + 4 * longint'(mCode) : b;
          mTgt = t[PW-1:0];
          mPhase = 2;
        end else if (mWaited < T) begin
          mWaited++;
          if (mWaited == T) mTo = 1;
        end
      end
      2: mPhase = 3;
      default: mPhase = 0;
    endcase
    mEdge = nEdge;
    mPrev = srcIn;
  endtask

  task automatic checkOutputs();
    chk("fetchStall", fetchStall, mPhase != 0);
    chk("triggerInterrupt", triggerInterrupt, mPhase == 2);
    chk("drainTimeout", drainTimeout, mTo);
    chk("pendingOut", pendingOut, modelPending());
    chk("interruptCode", interruptCode, mCode);
    chk("interruptRetAddr", interruptRetAddr, mRet);
    chk("interruptTargetAddr", interruptTargetAddr, mTgt);
  endtask

  task automatic cycle();
    #1;
    checkOutputs();
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic waitTrigger(input int maxCycles, input string name);
    bit got;
    got = 0;
    for (int n = 0; n < maxCycles && !got; n++) begin
      cycle();
      if (triggerInterrupt) got = 1;
    end
    chk(name, got, 1'b1);
  endtask

  typedef struct {
    bit          vec;
    bit [PW-1:0] base;
    bit [CWD-1:0] code;
    bit [PW-1:0] expTgt;
  } tgtVec_t;

  tgtVec_t tgtTab[6];
  int pulses, trigs;

  initial begin
    tgtTab[0] = '{1'b1, 32'h8000_0000, 5'd7,  32'h8000_001C};
    tgtTab[1] = '{1'b0, 32'h8000_0000, 5'd7,  32'h8000_0000};
    tgtTab[2] = '{1'b1, 32'h8000_0003, 5'd1,  32'h8000_0004};
    tgtTab[3] = '{1'b1, 32'hFFFF_FFFC, 5'd31, 32'h0000_0078};
    tgtTab[4] = '{1'b0, 32'h1234_5677, 5'd3,  32'h1234_5674};
    tgtTab[5] = '{1'b1, 32'h0000_0000, 5'd11, 32'h0000_002C};

    rst = 1'b0;
    globalEnable = 0; mtvecVectored = 1; pipelineEmpty = 0; recoveryBusy = 0;
    srcIn = '0; srcEnable = '0; srcClear = '0; mtvecBase = 32'h8000_0000; currentPC = 32'h100;
    srcCode = '0;
    srcCode[0*CWD +: CWD] = 5'd3;
    srcCode[1*CWD +: CWD] = 5'd7;
    srcCode[2*CWD +: CWD] = 5'd11;
    for (int i = 3; i < NS; i++) srcCode[i*CWD +: CWD] = CWD'(16 + i);
    modelReset();
    @(posedge clk); @(posedge clk); #1;
    checkOutputs();
    rst = 1'b1;

    // Level source 2: stall at +1, fire at +2 with the PC seen at drain exit.
    globalEnable = 1; srcEnable = '1; pipelineEmpty = 1; srcIn = 8'b0000_0100;
    cycle();
    chk("lat stall +1", fetchStall, 1'b1);
    chk("lat trig +1", triggerInterrupt, 1'b0);
    currentPC = 32'h104;
    cycle();
    chk("lat trig +2", triggerInterrupt, 1'b1);
    chk("lat code", interruptCode, 5'd11);
    chk("lat retAddr", interruptRetAddr, 32'h104);
    srcIn = '0;
    cycle(); cycle();

    for (int k = 0; k < 6; k++) begin
      mtvecVectored = tgtTab[k].vec;
      mtvecBase = tgtTab[k].base;
      srcCode[2*CWD +: CWD] = tgtTab[k].code;
      srcIn = 8'b0000_0100;
      waitTrigger(6, "tab trigger");
      chk("tab code", interruptCode, tgtTab[k].code);
      chk("tab target", interruptTargetAddr, tgtTab[k].expTgt);
      srcIn = '0;
      cycle(); cycle();
    end

    // Edge source 1 waits behind a busy pipeline; level source 0 overtakes it.
    pipelineEmpty = 0; srcIn = 8'b0000_0010;
    cycle();
    srcIn = '0;
    repeat (4) cycle();
    chk("edge drain stall", fetchStall, 1'b1);
    srcIn = 8'b0000_0001;
    cycle();
    pipelineEmpty = 1;
    waitTrigger(4, "prio first trigger");
    chk("prio first code", interruptCode, 5'd3);
    srcIn = '0;
    #1 chk("prio src1 still pending", pendingOut[1], 1'b1);
    waitTrigger(8, "prio second trigger");
    chk("prio second code", interruptCode, 5'd7);
    cycle();
    chk("prio src1 cleared", pendingOut[1], 1'b0);
    cycle();

    // Global enable dropping mid-drain aborts without firing.
    srcIn = 8'b0000_0100; pipelineEmpty = 0;
    cycle();
    chk("abort stall", fetchStall, 1'b1);
    globalEnable = 0;
    cycle();
    chk("abort stall drop", fetchStall, 1'b0);
    chk("abort no trigger", triggerInterrupt, 1'b0);
    srcIn = '0; globalEnable = 1;
    cycle();

    // Recovery manager busy: one timeout pulse, then fire once it frees up.
    srcIn = 8'b0000_0100; pipelineEmpty = 1; recoveryBusy = 1;
    pulses = 0; trigs = 0;
    repeat (T + 6) begin
      cycle();
      pulses += int'(drainTimeout);
      trigs += int'(triggerInterrupt);
    end
    chk("timeout pulses", pulses, 1);
    chk("timeout no fire", trigs, 0);
    recoveryBusy = 0;
    waitTrigger(3, "timeout late trigger");
    srcIn = '0;
    cycle(); cycle();

    // Edge and clear together: set wins; clear alone then drops it.
    srcEnable = 8'hDF; srcIn = 8'h20; srcClear = 8'h20;
    cycle();
    chk("set beats clear", pendingOut[5], 1'b1);
    cycle();
    chk("clear alone", pendingOut[5], 1'b0);
    srcClear = '0; srcIn = '0;
    cycle();

    // Async reset while draining.
    srcEnable = '1; pipelineEmpty = 0; srcIn = 8'h20;
    cycle(); cycle();
    chk("rst pre drain", fetchStall, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst fetchStall", fetchStall, 1'b0);
    chk("rst trigger", triggerInterrupt, 1'b0);
    chk("rst pendingOut", pendingOut, 8'h00);
    chk("rst code", interruptCode, 5'd0);
    chk("rst retAddr", interruptRetAddr, 32'h0);
    chk("rst target", interruptTargetAddr, 32'h0);
    chk("rst timeout", drainTimeout, 1'b0);
    @(posedge clk); #1;
    srcIn = '0;
    rst = 1'b1;
    modelReset();

    for (int i = 0; i < NS; i++) srcCode[i*CWD +: CWD] = CWD'($urandom);
    for (int n = 0; n < 2500; n++) begin
      srcIn = NS'($urandom & $urandom);
      srcEnable = NS'($urandom);
      srcClear = ($urandom_range(0, 7) == 0) ? NS'($urandom) : '0;
      globalEnable = ($urandom_range(0, 9) != 0);
      pipelineEmpty = ($urandom_range(0, 3) != 0);
      recoveryBusy = ((n % 400) < 30) ? 1'b1 : ($urandom_range(0, 4) == 0);
      currentPC = $urandom;
      if ($urandom_range(0, 15) == 0) begin
        mtvecBase = $urandom;
        mtvecVectored = $urandom_range(0, 1);
      end
      cycle();
    end
    #1 checkOutputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
